// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Optional round-robin tie-break is enabled with SRAM_ARB_ROUND_ROBIN_EN.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_A = 1'b0;
    localparam owner_t OWNER_B = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

    // Counter must be able to hold MAX_LOCK itself.
    function automatic int lock_cnt_width(input int max_lock);
        return clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// Combinational grant selection for the two SRAM requesters.
// Tie-break policy depends on SRAM_ARB_ROUND_ROBIN_EN (fixed A-priority when undefined).
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic       a_req,
    input  logic       b_req,
    input  arb_state_t state,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    input  owner_t     last_grant,
`endif
    input  logic       yield_valid,
    input  owner_t     yield_owner,
    output logic       a_grant,
    output logic       b_grant
);

    logic tie_to_b;

    // A side just force-released by the lock timeout loses the next tie.
    always_comb begin
        if (yield_valid) begin
            tie_to_b = (yield_owner == OWNER_A);
        end else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            tie_to_b = (last_grant == OWNER_A);
`else
            tie_to_b = 1'b0;
`endif
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        a_grant = 1'b0;
        b_grant = 1'b0;
        case (state)
            OWN_A: a_grant = a_req;
            OWN_B: b_grant = b_req;
            default: begin
                if (a_req && b_req) begin
                    a_grant = !tie_to_b;
                    b_grant = tie_to_b;
                end else begin
                    a_grant = a_req;
                    b_grant = b_req;
                end
            end
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port, byte-writable SRAM with locked sequences.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed A priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    a_req,
    input  logic                    a_lock,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    input  logic [DATA_WIDTH/8-1:0] a_write_en,
    output logic                    a_ack,
    output logic                    a_rd_valid,
    output logic [DATA_WIDTH-1:0]   a_dout,

    input  logic                    b_req,
    input  logic                    b_lock,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_din,
    input  logic [DATA_WIDTH/8-1:0] b_write_en,
    output logic                    b_ack,
    output logic                    b_rd_valid,
    output logic [DATA_WIDTH-1:0]   b_dout,

    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    output logic [DATA_WIDTH/8-1:0] mem_write_en,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = lock_cnt_width(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               yield_valid_q, yield_valid_d;
    owner_t             yield_owner_q, yield_owner_d;
    logic               pend_valid_q;
    owner_t             pend_owner_q;

    logic               a_grant, b_grant;
    logic               any_grant;
    owner_t             grant_owner;
    logic               grant_lock;
    logic [BE_W-1:0]    grant_we;
    logic               grant_read;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    owner_t             last_grant_q;
`endif

    sram_arb_pick u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .state       (state_q),
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_q),
`endif
        .yield_valid (yield_valid_q),
        .yield_owner (yield_owner_q),
        .a_grant     (a_grant),
        .b_grant     (b_grant)
    );

    assign a_ack       = a_grant;
    assign b_ack       = b_grant;
    assign any_grant   = a_grant || b_grant;
    assign grant_owner = b_grant ? OWNER_B : OWNER_A;
    assign grant_lock  = b_grant ? b_lock : a_lock;
    assign grant_we    = b_grant ? b_write_en : a_write_en;
    assign grant_read  = any_grant && (grant_we == '0);
    assign cnt_inc     = cnt_q + 1'b1;

    // Without a grant the address/data simply follow port A; the zero strobe makes it harmless.
    assign mem_addr     = b_grant ? b_addr : a_addr;
    assign mem_din      = b_grant ? b_din  : a_din;
    assign mem_write_en = ({BE_W{a_grant}} & a_write_en) | ({BE_W{b_grant}} & b_write_en);

    assign a_rd_valid = pend_valid_q && (pend_owner_q == OWNER_A);
    assign b_rd_valid = pend_valid_q && (pend_owner_q == OWNER_B);
    assign a_dout     = mem_dout;
    assign b_dout     = mem_dout;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        yield_valid_d = yield_valid_q;
        yield_owner_d = yield_owner_q;

        if ((state_q == IDLE) && any_grant) begin
            yield_valid_d = 1'b0;
        end

        if (any_grant) begin
            if (grant_lock) begin
                if (cnt_inc == CNT_MAX) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    yield_valid_d = 1'b1;
                    yield_owner_d = grant_owner;
                end else begin
                    state_d = (grant_owner == OWNER_B) ? OWN_B : OWN_A;
                    cnt_d   = cnt_inc;
                end
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                OWN_A: begin
                    if (!a_req && !a_lock) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                OWN_B: begin
                    if (!b_req && !b_lock) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            yield_valid_q <= 1'b0;
            yield_owner_q <= OWNER_A;
            pend_valid_q  <= 1'b0;
            pend_owner_q  <= OWNER_A;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            yield_valid_q <= yield_valid_d;
            yield_owner_q <= yield_owner_d;
            pend_valid_q  <= grant_read;
            pend_owner_q  <= grant_owner;
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= OWNER_A;
        end else if (any_grant) begin
            last_grant_q <= grant_owner;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an abstract arbitration model.
module tb_sram_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int ML = 4;

    logic          clk;
    logic          reset;
    logic          a_req, a_lock, b_req, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic [BW-1:0] a_write_en, b_write_en;
    logic          a_ack, b_ack, a_rd_valid, b_rd_valid;
    logic [DW-1:0] a_dout, b_dout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [BW-1:0] mem_write_en;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    // Abstract model: owner -1 none / 0 A / 1 B, count of locked grants, pending read.
    int            m_owner, m_cnt, m_yield, m_last;
    bit            m_pv;
    int            m_po;
    logic [DW-1:0] m_pd;
    bit            last_ga, last_gb;
    logic          s_a_ack, s_b_ack, s_a_rv, s_b_rv;
    logic [DW-1:0] s_a_dout, s_b_dout;
    logic [BW-1:0] s_mem_we;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_lock(a_lock), .a_addr(a_addr), .a_din(a_din), .a_write_en(a_write_en),
        .a_ack(a_ack), .a_rd_valid(a_rd_valid), .a_dout(a_dout),
        .b_req(b_req), .b_lock(b_lock), .b_addr(b_addr), .b_din(b_din), .b_write_en(b_write_en),
        .b_ack(b_ack), .b_rd_valid(b_rd_valid), .b_dout(b_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_write_en(mem_write_en), .mem_dout(mem_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-writable SRAM with one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < BW; i++) begin
            if (mem_write_en[i]) sram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
        end
        mem_dout <= sram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_yield = -1;
        m_last  = 0;
        m_pv    = 1'b0;
        m_po    = 0;
        m_pd    = '0;
    endtask

    task automatic set_a(input logic req, input logic lock, input int addr,
                         input logic [DW-1:0] din, input logic [BW-1:0] we);
        a_req = req; a_lock = lock; a_addr = AW'(addr); a_din = din; a_write_en = we;
    endtask

    task automatic set_b(input logic req, input logic lock, input int addr,
                         input logic [DW-1:0] din, input logic [BW-1:0] we);
        b_req = req; b_lock = lock; b_addr = AW'(addr); b_din = din; b_write_en = we;
    endtask

    // One clock: predict, check at negedge, advance the model at posedge.
    task automatic step();
        bit            ga, gb;
        int            win, g;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_din;
        logic [BW-1:0] g_we;
        logic          g_lock;
        ga = 1'b0;
        gb = 1'b0;
        if (m_owner == 0) ga = a_req;
        else if (m_owner == 1) gb = b_req;
        else if (a_req && b_req) begin
            if (m_yield >= 0) win = 1 - m_yield;
            else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                win = 1 - m_last;
`else
                win = 0;
`endif
            end
            ga = (win == 0);
            gb = (win == 1);
        end else begin
            ga = a_req;
            gb = b_req;
        end
        g      = gb ? 1 : 0;
        g_addr = gb ? b_addr : a_addr;
        g_din  = gb ? b_din : a_din;
        g_we   = gb ? b_write_en : a_write_en;
        g_lock = gb ? b_lock : a_lock;

        @(negedge clk);
        s_a_ack = a_ack; s_b_ack = b_ack; s_a_rv = a_rd_valid; s_b_rv = b_rd_valid;
        s_a_dout = a_dout; s_b_dout = b_dout; s_mem_we = mem_write_en;
        check("a_ack", a_ack, ga);
        check("b_ack", b_ack, gb);
        check("mem_write_en", mem_write_en, (ga || gb) ? g_we : '0);
        if (ga || gb) begin
            check("mem_addr", mem_addr, g_addr);
            check("mem_din", mem_din, g_din);
        end
        check("a_rd_valid", a_rd_valid, m_pv && (m_po == 0));
        check("b_rd_valid", b_rd_valid, m_pv && (m_po == 1));
        if (m_pv) check("rd_data", (m_po == 0) ? a_dout : b_dout, m_pd);

        @(posedge clk);
        m_pv = 1'b0;
        if (ga || gb) begin
            if (g_we == '0) begin
                m_pv = 1'b1;
                m_po = g;
                m_pd = exp_mem[g_addr];
            end else begin
                for (int i = 0; i < BW; i++)
                    if (g_we[i]) exp_mem[g_addr][8*i +: 8] = g_din[8*i +: 8];
            end
            if (m_owner < 0) m_yield = -1;
            m_last = g;
            if (g_lock) begin
                m_cnt++;
                if (m_cnt == ML) begin
                    m_owner = -1;
                    m_cnt   = 0;
                    m_yield = g;
                end else begin
                    m_owner = g;
                end
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end else if ((m_owner == 0 && !a_req && !a_lock) || (m_owner == 1 && !b_req && !b_lock)) begin
            m_owner = -1;
            m_cnt   = 0;
        end
        last_ga = ga;
        last_gb = gb;
        #1;
    endtask

    initial begin
        bit a_busy, b_busy;
        logic prev_a;
        reset = 1'b1;
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    <= '0;
            exp_mem[i]  = '0;
        end
        sram[16'h010] <= 32'hDEADBEEF; exp_mem[16'h010] = 32'hDEADBEEF;
        sram[16'h020] <= 32'hAAAAAAAA; exp_mem[16'h020] = 32'hAAAAAAAA;
        model_reset();

        // Reset state
        @(posedge clk); #1;
        check("rst_a_ack", a_ack, 1'b0);
        check("rst_a_rd_valid", a_rd_valid, 1'b0);
        check("rst_b_rd_valid", b_rd_valid, 1'b0);
        check("rst_mem_we", mem_write_en, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single read
        set_a(1, 0, 'h010, '0, '0); step();
        check("single_ack", s_a_ack, 1'b1);
        set_a(0, 0, 0, '0, '0); step();
        check("single_rv", s_a_rv, 1'b1);
        check("single_data", s_a_dout, 32'hDEADBEEF);
        check("single_b_rv", s_b_rv, 1'b0);

        // Byte write by B then read back
        set_b(1, 0, 'h020, 32'h11223344, 4'b0101); step();
        set_b(1, 0, 'h020, '0, '0); step();
        set_b(0, 0, 0, '0, '0); step();
        check("bytewr_rv", s_b_rv, 1'b1);
        check("bytewr_data", s_b_dout, 32'hAA22AA44);

        // Contention without lock
        set_a(1, 0, 'h010, '0, '0); set_b(1, 0, 'h020, '0, '0);
        step(); prev_a = s_a_ack;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            check("rr_alternate", s_a_ack, !prev_a);
`else
            check("fixed_a_wins", s_a_ack, 1'b1);
`endif
            prev_a = s_a_ack;
        end
        set_a(0, 0, 0, '0, '0); set_b(0, 0, 0, '0, '0); step();

        // Locked read-modify-write; B primes the last-grant so A wins the tie
        set_b(1, 0, 'h040, '0, '0); step();
        set_a(1, 1, 'h030, '0, '0); step();
        check("rmw_rd_a", s_a_ack, 1'b1);
        check("rmw_rd_b", s_b_ack, 1'b0);
        set_a(1, 0, 'h030, 32'hCAFE0000, 4'hF); step();
        check("rmw_wr_a", s_a_ack, 1'b1);
        check("rmw_wr_b", s_b_ack, 1'b0);
        set_a(0, 0, 0, '0, '0); step();
        check("rmw_b_after", s_b_ack, 1'b1);
        set_b(0, 0, 0, '0, '0); step();

        // Lock timeout
        set_b(1, 0, 'h040, '0, '0); step();
        set_a(1, 1, 'h010, '0, '0); set_b(1, 0, 'h020, '0, '0);
        for (int i = 0; i < ML; i++) begin
            step();
            check("timeout_a_grant", s_a_ack, 1'b1);
        end
        step();
        check("timeout_b_grant", s_b_ack, 1'b1);
        set_b(0, 0, 0, '0, '0); set_a(1, 0, 'h010, '0, '0); step();
        set_a(0, 0, 0, '0, '0); step();

        // Same-address write then read
        set_a(1, 0, 'h050, 32'h12345678, 4'hF); step();
        set_a(1, 0, 'h050, '0, '0); step();
        set_a(0, 0, 0, '0, '0); step();
        check("wr_rd_data", s_a_dout, 32'h12345678);

        // Reset mid-read
        set_a(1, 0, 'h010, '0, '0); step();
        set_a(0, 0, 0, '0, '0);
        reset = 1'b1;
        #1;
        check("midrst_rv", a_rd_valid, 1'b0);
        check("midrst_we", mem_write_en, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        step();
        check("postrst_rv", s_a_rv, 1'b0);
        set_a(1, 0, 'h020, '0, '0); step();
        set_a(0, 0, 0, '0, '0); step();
        check("postrst_data", s_a_dout, 32'hAA22AA44);

        // Random traffic; each port holds its request and payload until acked
        a_busy = 1'b0;
        b_busy = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!a_busy && $urandom_range(0, 2) != 0) begin
                a_busy = 1'b1;
                set_a(1, ($urandom_range(0, 3) == 0), $urandom_range(0, 31), DW'($urandom),
                      $urandom_range(0, 1) ? BW'($urandom) : '0);
            end
            if (!b_busy && $urandom_range(0, 2) != 0) begin
                b_busy = 1'b1;
                set_b(1, ($urandom_range(0, 3) == 0), $urandom_range(0, 31), DW'($urandom),
                      $urandom_range(0, 1) ? BW'($urandom) : '0);
            end
            a_req = a_busy;
            b_req = b_busy;
            step();
            if (last_ga) a_busy = 1'b0;
            if (last_gb) b_busy = 1'b0;
            a_req = a_busy;
            b_req = b_busy;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter sharing one byte-writable single-port SRAM (the `single_port_ram` macro, 1-cycle registered read latency) between the CPU data port (A) and the debug/DMA port (B). Grants at most one access per cycle, routes returned read data to the owning requester, and supports short locked sequences (read-modify-write) bounded by a lock timeout. Sits between the memory-mapped bus fabric and the SRAM instance.

## Interface
- ADDR_WIDTH, 14, word address width, matching the SRAM.
- DATA_WIDTH, 32, data width; a multiple of 8.
- MAX_LOCK, 8, maximum consecutive locked grants before a forced release; ≥ 1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req / b_req  in  1  access request, held until acked.
- a_lock / b_lock  in  1  keep ownership after this access.
- a_addr / b_addr  in  ADDR_WIDTH  word address.
- a_din / b_din  in  DATA_WIDTH  write data.
- a_write_en / b_write_en  in  DATA_WIDTH/8  byte enables; all-zero means read.
- a_ack / b_ack  out  1  access issued to the SRAM this cycle; combinational.
- a_rd_valid / b_rd_valid  out  1  read data valid, registered.
- a_dout / b_dout  out  DATA_WIDTH  read data; equals mem_dout, qualified by rd_valid.
- mem_addr  out  ADDR_WIDTH  to SRAM addr.
- mem_din  out  DATA_WIDTH  to SRAM din.
- mem_write_en  out  DATA_WIDTH/8  to SRAM write_en.
- mem_dout  in  DATA_WIDTH  from SRAM dout.

## Operation
- FSM states: IDLE, OWN_A, OWN_B.
- **IDLE**
  - Only one request: grant it.
  - Both requesting: priority rule (see Configuration).
- **OWN_X** (entered after a granted X access with x_lock=1)
  - X is the only requester that can be granted.
  - The other requester waits even while X is idle.
  - Each granted X access with x_lock=1 stays in OWN_X.
  - A granted access with x_lock=0 → IDLE.
  - x_req=0 with x_lock=0 → IDLE.
- **Lock counter**
  - Increments on each granted locked access.
  - At MAX_LOCK it forces → IDLE and clears, even if lock=1.
  - A pending other requester then wins the next arbitration under both priority modes; the locked side loses the tie once.
- **Issued access**
  - mem_addr, mem_din and mem_write_en = granted requester's addr, din and write_en (byte enables ANDed with the grant).
  - No grant: mem_write_en = 0; mem_addr/mem_din carry port A values (don't-care).
- **Reads**
  - A granted read sets a one-deep pending tag {valid, owner}.
  - Next cycle: the owner's rd_valid = 1.
- **Writes**: take effect at the grant edge; rd_valid is never raised for a write.
- **Back-to-back**: reads A then B on consecutive cycles → a_rd_valid then b_rd_valid on consecutive cycles.
- **Same-address conflict**: write-then-read on consecutive cycles returns the new data (SRAM ordering).

## Timing
- ack: combinational from req/state.
- Read latency: 1 cycle ack→rd_valid; full throughput of one access per cycle.
- Reset values:
  - state IDLE; lock counter 0; pending tag invalid; priority pointer = A.
  - ack, rd_valid and mem_write_en = 0.
- Reset asserted mid-read: pending read dropped; rd_valid stays 0 after release.
- A requester must hold req and its payload stable until ack. Dropping req early is legal: no access, no ack.

## Configuration
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: simultaneous requests in IDLE go to the port not granted most recently. A 1-bit last-grant register updates on every grant.
- Undefined: fixed priority, A always wins ties. B is served only when A is idle, or via the MAX_LOCK release. The last-grant register is not built.

## Structure
- Package sram_arb_pkg:
  - state encoding enum (IDLE, OWN_A, OWN_B);
  - owner constants OWNER_A=0, OWNER_B=1;
  - lock-counter width function clog2(MAX_LOCK+1).
- One sub-module is natural: sram_arb_pick. It is combinational: inputs req pair, state and last-grant; outputs grant pair. This keeps the priority policy (and the macro) isolated from the datapath mux and pipeline registers.

## Test plan
- Single read: A reads addr 0x010 (preloaded 0xDEADBEEF) → a_ack cycle 0; cycle 1 a_rd_valid=1, a_dout=0xDEADBEEF, b_rd_valid=0.
- Contention: a_req=b_req=1 continuously, no lock.
  - Round-robin build → grants alternate A,B,A,B.
  - Fixed build → A every cycle, b_ack never.
- Byte write: B writes 0x11223344 to addr 0x020 with write_en=4'b0101, preloaded 0xAAAAAAAA → subsequent read returns 0xAA22AA44.
- Lock RMW: A read lock=1, then write lock=0 while b_req=1 throughout → b_ack only after A's write ack.
- Lock timeout: MAX_LOCK=4, A holds lock=1 and req=1, b_req=1 → 4 A grants, then one B grant.
- Reset mid-read: assert reset on the cycle after an a_ack read → a_rd_valid=0, mem_write_en=0; after release the first granted read behaves normally.
